mem_bridge: RTL and testbench
=============================

# mem_bridge

Memory/IO bridge sitting directly downstream of the eLC-3 datapath's MAR/MDR pair. It turns the control unit's level-held `MIO_EN` + `R_W` request into a timed access to external asynchronous SRAM, or to a small memory-mapped I/O page. It returns read data on the path that feeds the datapath's MDR input. Completion is signalled with a one-cycle ready pulse `R` that the control unit waits on.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: number of cycles the SRAM strobes are held per access. Legal range 1..15.

Ports:
- `Clk`  in  1  system clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `MIO_EN`  in  1  access request from the control unit, held high until `R` is seen.
- `R_W`  in  1  access type: 1 = write, 0 = read. Sampled with the request.
- `Address`  in  16  access address, taken from the datapath MAR.
- `Data_Wr`  in  16  write data, taken from the datapath MDR.
- `Data_Rd`  out  16  registered read data, driven to the datapath RAM-data input.
- `R`  out  1  ready: a one-cycle pulse when the access completes.
- `SRAM_Addr`  out  16  registered SRAM address.
- `SRAM_DQ_Out`  out  16  registered SRAM write data.
- `SRAM_DQ_In`  in  16  SRAM read data.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`  out  1 each  active-low SRAM strobes.
- `Switches`  in  16  board switch value, readable over MMIO.
- `LED`  out  16  display register, writable over MMIO.

## Operation
- States: IDLE, ACCESS, DONE, HOLD.
- **IDLE**
  - `MIO_EN`=1 is sampled at the clock edge.
  - At that edge, latch `Address`, `Data_Wr` and `R_W` into internal registers.
  - Changes on these inputs after acceptance are ignored for the rest of the access.
  - I/O address (`Address` >= 16'hFE00): go to DONE.
  - Otherwise: load the wait counter with `WAIT_CYCLES`-1 and go to ACCESS.
- **ACCESS**
  - `SRAM_CE_N`=0 throughout.
  - Read: `SRAM_OE_N`=0. Write: `SRAM_WE_N`=0 and `SRAM_DQ_Out` = latched write data.
  - The counter decrements every cycle.
  - At the edge where the counter is 0: go to DONE; on a read, also capture `SRAM_DQ_In` into `Data_Rd`.
- **DONE**
  - `R`=1 for exactly this one cycle; all strobes are high.
  - Next state: HOLD if `MIO_EN`=1, else IDLE.
- **HOLD**
  - Wait for `MIO_EN`=0, then go to IDLE.
  - Because of this, a new request needs at least one cycle with `MIO_EN` low; back-to-back requests without a low cycle are never accepted.
- **MMIO page**
  - I/O accesses are decoded on the latched address and take effect on the IDLE→DONE edge.
  - Read 16'hFE00 (KBSR) or 16'hFE04 (DSR): `Data_Rd` = 16'h8000 (device always ready).
  - Read 16'hFE02 (KBDR): `Data_Rd` = `Switches`, sampled at that edge.
  - Write 16'hFE06 (DDR): `LED` = latched write data.
  - Any other I/O address: a read returns 16'h0000; a write is dropped. `R` still pulses.
  - I/O accesses never assert any SRAM strobe.
- **Data and address rules**
  - `Data_Rd` changes only on read completion; it holds its value across writes and idle periods.
  - `SRAM_Addr` follows the latched address and is stable for the whole ACCESS phase.

## Timing
- **Reset values** (applied immediately on `Reset`=0, regardless of `Clk`):
  - State = IDLE.
  - `R`=0; `Data_Rd`=0; `LED`=0.
  - `SRAM_Addr`=0; `SRAM_DQ_Out`=0.
  - `SRAM_CE_N` = `SRAM_OE_N` = `SRAM_WE_N` = 1.
- **Reset mid-access:** the access is aborted and strobes go high asynchronously. No `R` pulse is produced, and a partial read does not update `Data_Rd`.
- **SRAM latency:** if `MIO_EN` is first sampled high at edge E0, strobes are active for cycles E0..E0+`WAIT_CYCLES`-1. `R` is high in the cycle after edge E0+`WAIT_CYCLES`. Total latency from acceptance to `R` is `WAIT_CYCLES`+1 cycles.
- **MMIO latency:** `R` is high in the cycle after E0, i.e. 1 cycle.
- **`Data_Rd` validity:** valid in the same cycle `R` is high, and stays stable afterwards. The control unit loads MDR during the `R` cycle.
- **Output registration:** all outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Reset:** assert `Reset`=0 during ACCESS of a write (`WAIT_CYCLES`=2). Required: `SRAM_WE_N` goes high immediately, `R` is never asserted, `LED`=0, `Data_Rd`=0.
- **SRAM write, then read back:** write 16'h1234 to 16'h3000, then read 16'h3000 from an SRAM model. Required: `SRAM_WE_N` low for exactly 2 cycles; `R` pulses 3 cycles after acceptance; the read returns `Data_Rd`=16'h1234 in the `R` cycle.
- **Request held / no double access:** hold `MIO_EN` high for 6 cycles after `R`. Required: a single `R` pulse, FSM stays in HOLD, no strobes. After `MIO_EN` drops for 1 cycle, a new read is accepted.
- **MMIO:** `Switches`=16'hBEEF, read 16'hFE02 → `Data_Rd`=16'hBEEF with `R` 1 cycle after acceptance. Write 16'h0042 to 16'hFE06 → `LED`=16'h0042. Read 16'hFE04 → 16'h8000. Read 16'hFE10 → 16'h0000. No SRAM strobe is asserted throughout.
- **Address/data latching:** change `Address` and `Data_Wr` in the cycle after acceptance. Required: `SRAM_Addr` and `SRAM_DQ_Out` keep the originally latched values until DONE.
- **Parameter sweep:** `WAIT_CYCLES`=1 and 15. Required: strobes held 1 and 15 cycles respectively; `R` latency is 2 and 16 cycles respectively.

Source files
------------

// File: rtl/mem_bridge.sv
// Memory/IO bridge between the eLC-3 MAR/MDR and an asynchronous SRAM plus a small MMIO page.
// A level-held MIO_EN request becomes one timed access, finished by a single-cycle R pulse.
module mem_bridge #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MIO_EN,
   input  logic        R_W,
   input  logic [15:0] Address,
   input  logic [15:0] Data_Wr,
   output logic [15:0] Data_Rd,
   output logic        R,
   output logic [15:0] SRAM_Addr,
   output logic [15:0] SRAM_DQ_Out,
   input  logic [15:0] SRAM_DQ_In,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   input  logic [15:0] Switches,
   output logic [15:0] LED
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, HOLD} state_t;

   localparam logic [3:0] COUNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t      state, state_next;
   logic [3:0]  count;
   logic        rw_lat;
   logic        accept;
   logic        is_io;
   logic        rw_eff;
   logic        ce_n_next, oe_n_next, we_n_next, r_next;

   assign accept = (state == IDLE) && MIO_EN;
   assign is_io  = (Address >= 16'hFE00);
   assign rw_eff = accept ? R_W : rw_lat;

   // State register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (MIO_EN) state_next = is_io ? DONE : ACCESS;
         ACCESS:  if (count == 4'd0) state_next = DONE;
         DONE:    state_next = MIO_EN ? HOLD : IDLE;
         HOLD:    if (!MIO_EN) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: strobes and R are computed from the next state and then registered
   always_comb begin
      ce_n_next = 1'b1;
      oe_n_next = 1'b1;
      we_n_next = 1'b1;
      r_next    = 1'b0;
      if (state_next == ACCESS) begin
         ce_n_next = 1'b0;
         oe_n_next = rw_eff;
         we_n_next = !rw_eff;
      end
      if (state_next == DONE) begin
         r_next = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         SRAM_CE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         SRAM_WE_N <= 1'b1;
         R         <= 1'b0;
      end else begin
         SRAM_CE_N <= ce_n_next;
         SRAM_OE_N <= oe_n_next;
         SRAM_WE_N <= we_n_next;
         R         <= r_next;
      end
   end

   // Request latching, wait counter, read-data capture and the MMIO page
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         SRAM_Addr   <= 16'h0000;
         SRAM_DQ_Out <= 16'h0000;
         rw_lat      <= 1'b0;
         count       <= 4'd0;
         Data_Rd     <= 16'h0000;
         LED         <= 16'h0000;
      end else if (accept) begin
         SRAM_Addr   <= Address;
         SRAM_DQ_Out <= Data_Wr;
         rw_lat      <= R_W;
         count       <= COUNT_INIT;
         if (is_io) begin
            if (!R_W) begin
               case (Address)
                  16'hFE00, 16'hFE04: Data_Rd <= 16'h8000;
                  16'hFE02:           Data_Rd <= Switches;
                  default:            Data_Rd <= 16'h0000;
               endcase
            end else if (Address == 16'hFE06) begin
               LED <= Data_Wr;
            end
         end
      end else if (state == ACCESS) begin
         if (count == 4'd0) begin
            if (!rw_lat) Data_Rd <= SRAM_DQ_In;
         end else begin
            count <= count - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: three instances (WAIT_CYCLES 2, 1, 15) each with a small SRAM model.
// The driver pushes expected read data and latency; a monitor pops and checks on every R pulse.
module tb_mem_bridge;

   logic        clk;
   logic        rst_n;
   logic [2:0]  mio, rw, r, ce_n, oe_n, we_n;
   logic [15:0] addr [3];
   logic [15:0] wdata [3];
   logic [15:0] data_rd [3];
   logic [15:0] sram_addr [3];
   logic [15:0] dq_out [3];
   logic [15:0] dq_in [3];
   logic [15:0] led [3];
   logic [15:0] switches;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   typedef struct {
      int          inst;
      logic [15:0] data;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int WC = (gi == 0) ? 2 : (gi == 1) ? 1 : 15;
      logic [15:0] mem [0:255];

      mem_bridge #(.WAIT_CYCLES(WC)) u_dut (
         .Clk(clk), .Reset(rst_n), .MIO_EN(mio[gi]), .R_W(rw[gi]),
         .Address(addr[gi]), .Data_Wr(wdata[gi]), .Data_Rd(data_rd[gi]), .R(r[gi]),
         .SRAM_Addr(sram_addr[gi]), .SRAM_DQ_Out(dq_out[gi]), .SRAM_DQ_In(dq_in[gi]),
         .SRAM_CE_N(ce_n[gi]), .SRAM_OE_N(oe_n[gi]), .SRAM_WE_N(we_n[gi]),
         .Switches(switches), .LED(led[gi])
      );

      always @(posedge clk) begin
         if (!ce_n[gi] && !we_n[gi]) mem[sram_addr[gi][7:0]] <= dq_out[gi];
      end
      assign dq_in[gi] = mem[sram_addr[gi][7:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Monitor: every R pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst_n && r[i]) begin
            if (sb.size() == 0) begin
               chk($sformatf("unexpected_R_inst%0d", i), 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("R_instance", i, e.inst);
               chk($sformatf("Data_Rd_inst%0d", i), {16'h0, data_rd[i]}, {16'h0, e.data});
               chk($sformatf("R_latency_inst%0d", i), cyc - e.acc + 1, e.lat);
               $display("txn inst=%0d Data_Rd=%h latency=%0d", i, data_rd[i], cyc - e.acc + 1);
            end
         end
      end
   end

   task automatic access(input int inst, input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd, input int exp_lat, input int exp_strb,
                         input int hold, input bit scramble);
      int   ce_cnt, act_cnt, other_cnt, hold_strb;
      bit   got;
      exp_t e;
      ce_cnt = 0; act_cnt = 0; other_cnt = 0; hold_strb = 0; got = 0;
      @(negedge clk);
      rw[inst] = w; addr[inst] = a; wdata[inst] = d; mio[inst] = 1'b1;
      @(posedge clk); #1;
      e.inst = inst; e.data = exp_rd; e.acc = cyc; e.lat = exp_lat;
      sb.push_back(e);
      if (scramble) begin
         addr[inst]  = ~a;
         wdata[inst] = ~d;
      end
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (!ce_n[inst]) ce_cnt++;
         if (w ? !we_n[inst] : !oe_n[inst]) act_cnt++;
         if (w ? !oe_n[inst] : !we_n[inst]) other_cnt++;
         if (scramble) begin
            chk("latched_SRAM_Addr", {16'h0, sram_addr[inst]}, {16'h0, a});
            chk("latched_SRAM_DQ_Out", {16'h0, dq_out[inst]}, {16'h0, d});
         end
         if (r[inst]) got = 1;
      end
      chk("R_seen_before_timeout", {31'h0, got}, 32'd1);
      chk("CE_low_cycles", ce_cnt, exp_strb);
      chk(w ? "WE_low_cycles" : "OE_low_cycles", act_cnt, exp_strb);
      chk("wrong_strobe_cycles", other_cnt, 0);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (!ce_n[inst] || !oe_n[inst] || !we_n[inst]) hold_strb++;
      end
      if (hold > 0) chk("strobes_during_hold", hold_strb, 0);
      mio[inst] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; mio = '0; rw = '0; switches = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         addr[i] = 16'h0; wdata[i] = 16'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_R", {31'h0, r[0]}, 32'd0);
      chk("reset_Data_Rd", {16'h0, data_rd[0]}, 32'h0);
      chk("reset_LED", {16'h0, led[0]}, 32'h0);
      chk("reset_SRAM_Addr", {16'h0, sram_addr[0]}, 32'h0);
      chk("reset_SRAM_DQ_Out", {16'h0, dq_out[0]}, 32'h0);
      chk("reset_strobes", {29'h0, ce_n[0], oe_n[0], we_n[0]}, 32'h7);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset asserted while a write is in ACCESS
      @(negedge clk);
      rw[0] = 1'b1; addr[0] = 16'h3000; wdata[0] = 16'hAAAA; mio[0] = 1'b1;
      @(posedge clk); #1;
      chk("access_WE_low", {31'h0, we_n[0]}, 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("abort_WE_high", {31'h0, we_n[0]}, 32'd1);
      chk("abort_CE_high", {31'h0, ce_n[0]}, 32'd1);
      chk("abort_R_low", {31'h0, r[0]}, 32'd0);
      chk("abort_LED", {16'h0, led[0]}, 32'h0);
      chk("abort_Data_Rd", {16'h0, data_rd[0]}, 32'h0);
      mio[0] = 1'b0;
      @(negedge clk); #2;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_abort_R_low", {31'h0, r[0]}, 32'd0);

      // SRAM write then read back, WAIT_CYCLES=2
      access(0, 1'b1, 16'h3000, 16'h1234, 16'h0000, 3, 2, 0, 1'b0);
      access(0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 3, 2, 0, 1'b0);
      // Request held 6 cycles after R, then new accesses after one low cycle
      access(0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 3, 2, 6, 1'b0);
      access(0, 1'b1, 16'h3005, 16'hCAFE, 16'h1234, 3, 2, 0, 1'b0);
      access(0, 1'b0, 16'h3005, 16'h0000, 16'hCAFE, 3, 2, 0, 1'b0);

      // MMIO page
      switches = 16'hBEEF;
      access(0, 1'b0, 16'hFE02, 16'h0000, 16'hBEEF, 1, 0, 0, 1'b0);
      access(0, 1'b1, 16'hFE06, 16'h0042, 16'hBEEF, 1, 0, 0, 1'b0);
      chk("LED_after_DDR_write", {16'h0, led[0]}, 32'h0042);
      access(0, 1'b0, 16'hFE04, 16'h0000, 16'h8000, 1, 0, 0, 1'b0);
      access(0, 1'b0, 16'hFE10, 16'h0000, 16'h0000, 1, 0, 0, 1'b0);
      access(0, 1'b1, 16'hFE08, 16'h1111, 16'h0000, 1, 0, 0, 1'b0);
      chk("LED_after_dropped_write", {16'h0, led[0]}, 32'h0042);
      access(0, 1'b0, 16'hFE00, 16'h0000, 16'h8000, 1, 0, 2, 1'b0);

      // Inputs change right after acceptance; latched values must hold
      access(0, 1'b1, 16'h3011, 16'h5555, 16'h8000, 3, 2, 0, 1'b1);
      access(0, 1'b0, 16'h3011, 16'h0000, 16'h5555, 3, 2, 0, 1'b0);

      // Parameter sweep: WAIT_CYCLES=1 and 15
      access(1, 1'b1, 16'h3020, 16'h0F0F, 16'h0000, 2, 1, 0, 1'b0);
      access(1, 1'b0, 16'h3020, 16'h0000, 16'h0F0F, 2, 1, 0, 1'b0);
      access(2, 1'b1, 16'h3021, 16'hA5A5, 16'h0000, 16, 15, 0, 1'b0);
      access(2, 1'b0, 16'h3021, 16'h0000, 16'hA5A5, 16, 15, 0, 1'b0);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
